// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives the pc register and a single
// outstanding imem fetch, arbitrates redirects and squashes wrong-path data.
module fetch_ctrl #(
  parameter int IMEM_AW = 32,
  parameter int ILEN    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IMEM_AW-1:0] pc_cur,
  output logic               pc_jmp,
  output logic               pc_rel,
  output logic [IMEM_AW-1:0] pc_nxt,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [ILEN-1:0]    imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ILEN-1:0]    if_inst,
  output logic [IMEM_AW-1:0] if_pc,
  input  logic               trap_valid,
  input  logic [IMEM_AW-1:0] trap_target,
  input  logic               ex_redir,
  input  logic [IMEM_AW-1:0] ex_target
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    VALID
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               kill;
  logic               kill_nxt;
  logic [IMEM_AW-1:0] req_pc;
  logic               redir;
  logic [IMEM_AW-1:0] redir_tgt;
  logic               take;

  // Redirects are ignored in IDLE so reset release fetches the reset vector.
  assign redir     = (state != IDLE) && (trap_valid || ex_redir);
  assign redir_tgt = trap_valid ? trap_target : ex_target;

  assign take = (state == WAIT) && imem_rvalid
             && !kill && !redir;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_nxt = WAIT;
          kill_nxt  = redir;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nxt = (kill || redir) ? REQ : VALID;
          kill_nxt  = 1'b0;
        end else if (redir) begin
          kill_nxt = 1'b1;
        end
      end
      VALID: begin
        if (redir || if_ready) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      kill     <= 1'b0;
      req_pc   <= '0;
      if_valid <= 1'b0;
      if_inst  <= '0;
      if_pc    <= '0;
    end else begin
      kill     <= kill_nxt;
      if_valid <= (state_nxt == VALID);
      if (state == REQ) begin
        req_pc <= pc_cur;
      end
      if (take) begin
        if_inst <= imem_rdata;
        if_pc   <= req_pc;
      end
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    pc_jmp    = 1'b1;
    pc_rel    = 1'b1;
    pc_nxt    = '0;
    if (rst) begin
      if (state == REQ) begin
        imem_req  = 1'b1;
        imem_addr = pc_cur;
        if (imem_gnt) begin
          pc_jmp = 1'b0;
          pc_rel = 1'b0;
        end
      end
      if (redir) begin
        pc_jmp = 1'b1;
        pc_rel = 1'b0;
        pc_nxt = redir_tgt;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: pc register and imem models, cycle table,
// directed corner cases and random traffic checked by a stream scoreboard.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic        pc_jmp;
  logic        pc_rel;
  logic [31:0] pc_nxt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        ex_redir;
  logic [31:0] ex_target;

  always #5 clk = ~clk;

  fetch_ctrl #(.IMEM_AW(32), .ILEN(32)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur),
    .pc_jmp(pc_jmp), .pc_rel(pc_rel), .pc_nxt(pc_nxt),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .ex_redir(ex_redir), .ex_target(ex_target)
  );

  typedef struct {
    bit          gnt;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          jmp;
    bit          rel;
    logic [31:0] nxt;
    bit          vld;
    logic [31:0] ifpc;
  } vec_t;

  vec_t tbl[$];

  int          n_vec = 0;
  int          n_bad = 0;
  bit          mem_busy;
  int          mem_left;
  logic [31:0] mem_a;
  int          lat = 1;
  bit          lat_rand = 1'b0;
  logic [31:0] exp_pc;
  int          since_rst;
  bit          hand;
  logic [31:0] hand_pc;
  bit          granted;
  int          n_hand = 0;
  bit          prev_hold;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;
  bit          rv;
  bit          gr;
  logic [31:0] ga;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic vec_t mk(
    input bit g, input bit r, input bit q, input logic [31:0] a,
    input bit j, input bit l, input logic [31:0] n,
    input bit v, input logic [31:0] p);
    vec_t t;
    t.gnt = g; t.rdy = r; t.req = q; t.addr = a;
    t.jmp = j; t.rel = l; t.nxt = n; t.vld = v; t.ifpc = p;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timeout, got no event want one at %0t", nm, $time);
  endtask

  // First half of a cycle: memory answers, then outputs are checked.
  task automatic pre();
    logic [31:0] tgt;
    bit          redir;
    rv = mem_busy && (mem_left == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? word(mem_a) : 32'hDEADBEEF;
    #2;
    redir = rst && since_rst > 0 && (trap_valid || ex_redir);
    tgt   = trap_valid ? trap_target : ex_target;
    gr    = rst && imem_req && imem_gnt;
    ga    = imem_addr;
    hand  = 1'b0;
    if (rst) begin
      if (prev_hold) begin
        chk("hold_valid", if_valid, 1);
        chk("hold_pc", if_pc, prev_pc);
        chk("hold_inst", if_inst, prev_inst);
      end
      if (imem_req) chk("imem_addr", imem_addr, pc_cur);
      if (gr) chk("one_outstanding", 32'(mem_busy && !rv), 0);
      if (redir) begin
        chk("redir_jmp", pc_jmp, 1);
        chk("redir_rel", pc_rel, 0);
        chk("redir_nxt", pc_nxt, tgt);
        exp_pc = tgt;
      end else if (if_valid && if_ready) begin
        hand    = 1'b1;
        hand_pc = if_pc;
        n_hand++;
        chk("hand_pc", if_pc, exp_pc);
        chk("hand_inst", if_inst, word(if_pc));
        exp_pc = if_pc + 32'd4;
      end
      prev_hold = if_valid && !if_ready && !redir;
      prev_pc   = if_pc;
      prev_inst = if_inst;
    end
  endtask

  // Second half: pc register and memory advance across the edge.
  task automatic post();
    logic [31:0] pc_n;
    if (!rst) pc_n = 32'h0;
    else if (!pc_jmp) pc_n = pc_cur + 32'd4;
    else if (pc_rel) pc_n = pc_cur + pc_nxt;
    else pc_n = pc_nxt;
    granted = gr;
    @(posedge clk);
    #1;
    pc_cur = pc_n;
    if (!rst) begin
      mem_busy  = 1'b0;
      since_rst = 0;
      exp_pc    = 32'h0;
      prev_hold = 1'b0;
    end else begin
      since_rst++;
      if (gr) begin
        mem_busy = 1'b1;
        mem_a    = ga;
        mem_left = lat_rand ? int'($urandom_range(2, 0)) : lat - 1;
      end else if (rv) begin
        mem_busy = 1'b0;
      end else if (mem_busy && mem_left > 0) begin
        mem_left--;
      end
    end
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  task automatic quiet();
    imem_gnt   = 1'b1;
    if_ready   = 1'b1;
    trap_valid = 1'b0;
    ex_redir   = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_ifpc", if_pc, 0);
    chk("rst_jmp", pc_jmp, 1);
    chk("rst_rel", pc_rel, 1);
    chk("rst_nxt", pc_nxt, 0);
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b0;
    cycle();
    cycle();
    chk_reset();
    rst = 1'b1;
  endtask

  task automatic wait_hand(input string nm, input logic [31:0] want);
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      cycle();
      if (hand) ok = 1'b1;
    end
    if (ok) chk(nm, hand_pc, want);
    else timeout(nm);
  endtask

  task automatic wait_grant(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle();
      if (granted) ok = 1'b1;
    end
    if (!ok) timeout(nm);
  endtask

  initial begin
    int base;
    bit ok;
    rst = 1'b0; pc_cur = 32'h0;
    imem_gnt = 1'b0; if_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    trap_valid = 1'b0; trap_target = 32'h0;
    ex_redir = 1'b0; ex_target = 32'h0;
    mem_busy = 1'b0; mem_left = 0; mem_a = 32'h0;
    exp_pc = 32'h0; since_rst = 0; prev_hold = 1'b0;

    // Streaming from 0 with 1-cycle memory, then grant withheld at 0x10.
    tbl.push_back(mk(1, 1, 0, 32'h00, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 1, 32'h00, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h00, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h00, 1, 1, 0, 1, 32'h0));
    tbl.push_back(mk(1, 1, 1, 32'h04, 0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h00, 1, 1, 0, 0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h00, 1, 1, 0, 1, 32'h4));
    tbl.push_back(mk(1, 1, 1, 32'h08, 0, 0, 0, 0, 32'h4));
    tbl.push_back(mk(1, 1, 0, 32'h00, 1, 1, 0, 0, 32'h4));
    tbl.push_back(mk(1, 1, 0, 32'h00, 1, 1, 0, 1, 32'h8));
    tbl.push_back(mk(1, 1, 1, 32'h0C, 0, 0, 0, 0, 32'h8));
    tbl.push_back(mk(1, 1, 0, 32'h00, 1, 1, 0, 0, 32'h8));
    tbl.push_back(mk(1, 1, 0, 32'h00, 1, 1, 0, 1, 32'hC));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 1, 32'h10, 1, 1, 0, 0, 32'hC));
    tbl.push_back(mk(1, 1, 1, 32'h10, 0, 0, 0, 0, 32'hC));
    tbl.push_back(mk(1, 1, 0, 32'h00, 1, 1, 0, 0, 32'hC));
    tbl.push_back(mk(1, 1, 0, 32'h00, 1, 1, 0, 1, 32'h10));

    lat = 1;
    do_reset();
    foreach (tbl[i]) begin
      imem_gnt = tbl[i].gnt;
      if_ready = tbl[i].rdy;
      pre();
      chk("t_req", imem_req, tbl[i].req);
      chk("t_addr", imem_addr, tbl[i].addr);
      chk("t_jmp", pc_jmp, tbl[i].jmp);
      if (tbl[i].jmp) begin
        chk("t_rel", pc_rel, tbl[i].rel);
        chk("t_nxt", pc_nxt, tbl[i].nxt);
      end
      chk("t_valid", if_valid, tbl[i].vld);
      chk("t_ifpc", if_pc, tbl[i].ifpc);
      if (tbl[i].vld) chk("t_inst", if_inst, word(tbl[i].ifpc));
      post();
    end

    // Decode stalls with 0x8 buffered.
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if_ready = !(if_valid && if_pc == 32'h8);
      if (!if_ready) ok = 1'b1;
      else cycle();
    end
    if (!ok) timeout("stall_reach");
    for (int i = 0; i < 5; i++) begin
      if_ready = 1'b0;
      pre();
      chk("stall_valid", if_valid, 1);
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_inst", if_inst, word(32'h8));
      chk("stall_req", imem_req, 0);
      post();
    end
    if_ready = 1'b1;
    cycle();
    chk("stall_hand", hand, 1);
    pre();
    chk("after_req", imem_req, 1);
    chk("after_addr", imem_addr, 32'hC);
    post();

    // Execute redirect in WAIT, response two cycles late.
    do_reset();
    lat = 3;
    wait_grant("ex_grant");
    ex_redir = 1'b1;
    ex_target = 32'h1000;
    pre();
    chk("ex_nxt", pc_nxt, 32'h1000);
    chk("ex_rel", pc_rel, 0);
    post();
    ex_redir = 1'b0;
    lat = 1;
    wait_hand("ex_first_pc", 32'h1000);

    // Trap and execute redirect together while VALID.
    do_reset();
    if_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (if_valid) ok = 1'b1;
      else cycle();
    end
    if (!ok) timeout("trap_reach");
    trap_valid = 1'b1; trap_target = 32'h80;
    ex_redir = 1'b1; ex_target = 32'h1000;
    if_ready = 1'b1;
    cycle();
    quiet();
    chk("trap_pc_cur", pc_cur, 32'h80);
    chk("trap_drop", if_valid, 0);
    wait_hand("trap_first_pc", 32'h80);

    // Reset in the middle of WAIT.
    do_reset();
    lat = 3;
    wait_grant("rst_grant");
    cycle();
    rst = 1'b0;
    cycle();
    chk_reset();
    rst = 1'b1;
    lat = 1;
    chk("rst_no_stale", if_valid, 0);
    wait_hand("rst_first_pc", 32'h0);

    // Redirect during IDLE is ignored.
    do_reset();
    ex_redir = 1'b1;
    ex_target = 32'h2000;
    cycle();
    ex_redir = 1'b0;
    wait_hand("idle_first_pc", 32'h0);

    // Random traffic against the stream scoreboard.
    do_reset();
    lat_rand = 1'b1;
    base = n_hand;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(31, 0));
      imem_gnt    = ($urandom_range(3, 0) != 0);
      if_ready    = ($urandom_range(2, 0) != 0);
      trap_valid  = (since_rst > 0) && (r == 0);
      ex_redir    = (since_rst > 0) && (r < 3);
      trap_target = $urandom & 32'hFFFF_FFFC;
      ex_target   = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8
                                                : ($urandom & 32'hFFFF_FFFC);
      rst         = ($urandom_range(399, 0) != 0);
      cycle();
    end
    rst = 1'b1;
    quiet();
    chk("rand_progress", 32'(n_hand - base >= 150), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter and the instruction-memory fetch port for the single-issue core.
- Decides each cycle whether the pc register advances by 4, holds, or takes an absolute redirect.
- Issues one outstanding fetch at a time and hands each fetched instruction, tagged with its pc, to decode.
- Redirects from trap logic and from the execute stage are arbitrated here, and wrong-path fetches are squashed here.

Parameters:
- IMEM_AW, 32, width of instruction address and pc.
- ILEN, 32, instruction width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- pc_cur  in  IMEM_AW  current pc register value.
- pc_jmp  out  1  pc load enable.
- pc_rel  out  1  relative load (pc <= pc_cur + pc_nxt).
- pc_nxt  out  IMEM_AW  load value or offset.
- imem_req  out  1  fetch request.
- imem_addr  out  IMEM_AW  fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  ILEN  read data.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts.
- if_inst  out  ILEN  instruction.
- if_pc  out  IMEM_AW  address of if_inst.
- trap_valid  in  1  trap redirect request.
- trap_target  in  IMEM_AW  trap handler address.
- ex_redir  in  1  branch/jump redirect request from execute.
- ex_target  in  IMEM_AW  absolute redirect target.

Behaviour:
- pc register contract, evaluated at each edge:
  - pc_jmp=0: pc_cur+4.
  - pc_jmp=1, pc_rel=0: pc_nxt.
  - pc_jmp=1, pc_rel=1: pc_cur+pc_nxt.
  - Hold is encoded as pc_jmp=1, pc_rel=1, pc_nxt=0.
- Reset (rst=0 at an edge):
  - state=IDLE; kill=0.
  - Outputs: imem_req=0, imem_addr=0, if_valid=0, if_inst=0, if_pc=0, pc_jmp=1, pc_rel=1, pc_nxt=0 (hold).
  - imem is reset by the same rst, so no response is outstanding after reset.
- FSM states: IDLE, REQ, WAIT, VALID.
- IDLE:
  - pc held, no request.
  - Next cycle goes to REQ.
- REQ:
  - imem_req=1, imem_addr=pc_cur, and req_pc is captured from pc_cur.
  - If imem_gnt=1: pc advances (pc_jmp=0), go to WAIT.
  - If imem_gnt=0: pc held, stay in REQ with the address stable.
- WAIT:
  - pc held, imem_req=0.
  - On imem_rvalid=1 with kill=0: register imem_rdata into if_inst and req_pc into if_pc, go to VALID. if_valid rises the next cycle.
  - On imem_rvalid=1 with kill=1: discard the data, clear kill, go to REQ.
- VALID:
  - if_valid=1; if_inst and if_pc stay stable while if_ready=0.
  - On if_ready=1: go to REQ.
  - Throughput is one instruction per 3 cycles minimum (REQ, WAIT, VALID), with 1-cycle memory.
- Redirect arbitration, checked every non-IDLE cycle:
  - trap_valid has priority over ex_redir.
  - The winning target drives pc_jmp=1, pc_rel=0, pc_nxt=target. This overrides both the +4 and the hold.
  - In REQ with gnt=1 in the same cycle: the old-address fetch is in flight, so set kill=1 and go to WAIT.
  - In REQ with gnt=0: stay in REQ. The next cycle requests the new pc_cur.
  - In WAIT with no rvalid: set kill=1.
  - In WAIT with rvalid in the same cycle: drop the data, go to REQ, kill stays 0.
  - In VALID: drop the buffer (if_valid=0 next cycle), go to REQ. if_ready in the same cycle is ignored, so no handoff occurs.
  - A redirect in IDLE is ignored; reset release always fetches from the pc reset vector.
- Back-to-back redirects: the latest one wins. kill stays set (single flag, one outstanding fetch max).
- All address arithmetic is modulo 2^IMEM_AW; wrap from 0xFFFFFFFC+4 to 0 is legal.
- Registered outputs: if_valid, if_inst, if_pc, kill, state.
- Combinational outputs: imem_req, imem_addr, pc_jmp, pc_rel, pc_nxt.

Test Plan:
- Reset with pc model at 0x0, 1-cycle imem, if_ready=1 -> if_pc sequence 0x0, 0x4, 0x8, one valid every 3 cycles; if_inst matches memory contents.
- imem_gnt withheld 4 cycles in REQ at pc 0x10 -> imem_addr stays 0x10, pc_cur stays 0x10 (pc_jmp=1, pc_rel=1, pc_nxt=0), then normal fetch.
- if_ready=0 for 5 cycles with if_pc=0x8 -> if_valid, if_inst, if_pc stable; no new imem_req until the handoff.
- ex_redir=1, ex_target=0x1000 in WAIT with the response 2 cycles late -> pc_nxt=0x1000, pc_rel=0; the late response is dropped; the next if_pc is 0x1000.
- trap_valid (0x80) and ex_redir (0x1000) in the same cycle during VALID -> pc_cur becomes 0x80, if_valid drops, the next if_pc is 0x80.
- rst=0 asserted mid-WAIT -> after release all outputs are at reset values and the fetch restarts at the pc reset vector with no stale if_valid.
